cpu_fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS core. It owns the program counter, drives the instruction-memory address, and latches fetched instructions into the ID stage. It consumes the `stalls`/`flushs` vectors from the hazard unit and the branch/jump redirect from EX. It detects `syscall` to halt fetch, and keeps fetch and bubble statistics for the debug display.

---
 rtl/cpu_fetch_stage_pkg.sv | 30 +++
 rtl/cpu_if_id_reg.sv | 48 ++++
 rtl/cpu_fetch_stage.sv | 93 +++++++++
 tb/tb_cpu_fetch_stage.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_stage_pkg.sv
// Shared encodings for the fetch stage: PC actions from EX, hazard vector
// bit positions and fetch FSM states.
package cpu_fetch_stage_pkg;

  localparam logic [1:0] PC_INC_NORMAL = 2'd0;
  localparam logic [1:0] PC_INC_BRANCH = 2'd1;
  localparam logic [1:0] PC_INC_JUMP   = 2'd2;

  localparam int HAZARD_STALL_IF  = 0;
  localparam int HAZARD_STALL_ID  = 1;
  localparam int HAZARD_STALL_EX  = 2;
  localparam int HAZARD_STALL_MEM = 3;
  localparam int HAZARD_STALL_WB  = 4;

  localparam int HAZARD_FLUSH_IF  = 0;
  localparam int HAZARD_FLUSH_ID  = 1;
  localparam int HAZARD_FLUSH_EX  = 2;
  localparam int HAZARD_FLUSH_MEM = 3;
  localparam int HAZARD_FLUSH_WB  = 4;

  typedef enum logic {
    FETCH_RUN    = 1'b0,
    FETCH_HALTED = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/cpu_if_id_reg.sv
// IF/ID pipeline register: flush > stall(hold) > bubble request > load.
// Exposes which of load/bubble/hold happened this cycle for the statistics.
module cpu_if_id_reg
  import cpu_fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        clr_n,
  input  logic        flush_i,
  input  logic        stall_i,
  input  logic        bubble_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] instr_o,
  output logic        valid_o,
  output logic        load_o,
  output logic        bubble_o,
  output logic        hold_o
);

  logic [31:0] pc_q, pc_plus4_q, instr_q;
  logic        valid_q;

  assign bubble_o = flush_i | (!stall_i & bubble_i);
  assign hold_o   = !flush_i & stall_i;
  assign load_o   = !flush_i & !stall_i & !bubble_i;

  always_ff @(posedge clk) begin
    if (!clr_n || bubble_o) begin
      pc_q       <= '0;
      pc_plus4_q <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
    end else if (load_o) begin
      pc_q       <= pc_i;
      pc_plus4_q <= pc_plus4(pc_i);
      instr_q    <= instr_i;
      valid_q    <= 1'b1;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;
  assign instr_o    = instr_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/cpu_fetch_stage.sv
// Instruction fetch stage: PC, syscall halt FSM, statistics counters and
// the IF/ID register instance.
module cpu_fetch_stage
  import cpu_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'h0000_000C
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [4:0]  stalls,
  input  logic [4:0]  flushs,
  input  logic [1:0]  pc_inc_ex,
  input  logic [31:0] pc_target_ex,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc_id,
  output logic [31:0] pc_plus4_id,
  output logic [31:0] instr_id,
  output logic        valid_id,
  output logic        halted,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count,
  output logic [31:0] stall_count
);

  logic [31:0]  pc_q, pc_d;
  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_cnt_q, bubble_cnt_q, stall_cnt_q;
  logic         redirect, hold_pc, is_halted, halt_hit;
  logic         id_load, id_bubble, id_hold;
  logic         unused_hazard_bits;

  assign unused_hazard_bits = ^{stalls[4:2], flushs[4:2], flushs[0]};

  assign redirect  = (pc_inc_ex != PC_INC_NORMAL);
  assign hold_pc   = stalls[HAZARD_STALL_IF] | stalls[HAZARD_STALL_ID];
  assign is_halted = (state_q == FETCH_HALTED);
  // The syscall itself enters ID but the PC stays parked on it.
  assign halt_hit  = id_load && (imem_data == HALT_INSTR);

  cpu_if_id_reg u_if_id (
    .clk        (clk),
    .clr_n      (clr_n),
    .flush_i    (flushs[HAZARD_FLUSH_ID] | redirect),
    .stall_i    (stalls[HAZARD_STALL_ID]),
    .bubble_i   (stalls[HAZARD_STALL_IF] | is_halted),
    .pc_i       (pc_q),
    .instr_i    (imem_data),
    .pc_o       (pc_id),
    .pc_plus4_o (pc_plus4_id),
    .instr_o    (instr_id),
    .valid_o    (valid_id),
    .load_o     (id_load),
    .bubble_o   (id_bubble),
    .hold_o     (id_hold)
  );

  always_comb begin
    pc_d    = pc_plus4(pc_q);
    state_d = state_q;
    if (redirect)                          pc_d = pc_target_ex;
    else if (is_halted || hold_pc || halt_hit) pc_d = pc_q;
    case (state_q)
      FETCH_RUN:    if (halt_hit) state_d = FETCH_HALTED;
      FETCH_HALTED: if (redirect) state_d = FETCH_RUN;
      default:      state_d = FETCH_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      pc_q         <= RESET_PC;
      state_q      <= FETCH_RUN;
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      if (id_load)   fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (id_bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
      if (id_hold)   stall_cnt_q  <= stall_cnt_q + 32'd1;
    end
  end

  assign imem_addr    = pc_q;
  assign halted       = is_halted;
  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;
  assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_cpu_fetch_stage.sv
// Directed bench for cpu_fetch_stage: reset, stalls, redirect priority,
// syscall halt/resume, reset during halt and PC wrap.
module tb_cpu_fetch_stage;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [4:0]  stalls, flushs;
  logic [1:0]  pc_inc_ex;
  logic [31:0] pc_target_ex, imem_addr, imem_data;
  logic [31:0] pc_id, pc_plus4_id, instr_id;
  logic        valid_id, halted;
  logic [31:0] fetch_count, bubble_count, stall_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Instruction memory: fixed word at 0x100, syscall at 0x20, else 0x24000000|addr.
  always_comb begin
    if (imem_addr == 32'h100)      imem_data = 32'h2008_0001;
    else if (imem_addr == 32'h20)  imem_data = 32'h0000_000C;
    else                           imem_data = 32'h2400_0000 | imem_addr;
  end

  cpu_fetch_stage #(.RESET_PC(32'h100), .HALT_INSTR(32'h0000_000C)) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .stalls       (stalls),
    .flushs       (flushs),
    .pc_inc_ex    (pc_inc_ex),
    .pc_target_ex (pc_target_ex),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .pc_id        (pc_id),
    .pc_plus4_id  (pc_plus4_id),
    .instr_id     (instr_id),
    .valid_id     (valid_id),
    .halted       (halted),
    .fetch_count  (fetch_count),
    .bubble_count (bubble_count),
    .stall_count  (stall_count)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic redirect_to(input logic [1:0] kind, input logic [31:0] tgt);
    pc_inc_ex = kind; pc_target_ex = tgt;
    step();
    pc_inc_ex = 2'd0; pc_target_ex = '0;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; stalls = '0; flushs = '0; pc_inc_ex = 2'd0; pc_target_ex = '0;
    step(); step();
    vectors++; if (imem_addr !== 32'h100) begin miscompares++; $display("FAIL rst_pc got %h exp %h", imem_addr, 32'h100); end
    vectors++; if ({valid_id, halted} !== 2'b00) begin miscompares++; $display("FAIL rst_flags got %b exp 00", {valid_id, halted}); end
    vectors++; if ({pc_id, pc_plus4_id, instr_id} !== 96'h0) begin miscompares++; $display("FAIL rst_id got %h exp 0", {pc_id, pc_plus4_id, instr_id}); end
    vectors++; if ({fetch_count, bubble_count, stall_count} !== 96'h0) begin miscompares++; $display("FAIL rst_cnt got %h exp 0", {fetch_count, bubble_count, stall_count}); end
    clr_n = 1'b1;
    step();
    vectors++; if (imem_addr !== 32'h104) begin miscompares++; $display("FAIL first_pc got %h exp %h", imem_addr, 32'h104); end
    vectors++; if (pc_id !== 32'h100 || pc_plus4_id !== 32'h104) begin miscompares++; $display("FAIL first_pcid got %h/%h exp 100/104", pc_id, pc_plus4_id); end
    vectors++; if (instr_id !== 32'h2008_0001 || valid_id !== 1'b1) begin miscompares++; $display("FAIL first_instr got %h v%b exp 20080001 v1", instr_id, valid_id); end
    vectors++; if (fetch_count !== 32'd1 || bubble_count !== 32'd0) begin miscompares++; $display("FAIL first_cnt got f%0d b%0d exp f1 b0", fetch_count, bubble_count); end
  endtask

  task automatic test_stall();
    redirect_to(2'd2, 32'h0C);
    vectors++; if (imem_addr !== 32'h0C || valid_id !== 1'b0 || bubble_count !== 32'd1) begin miscompares++; $display("FAIL jmp_bubble got pc %h v%b b%0d exp 0c v0 b1", imem_addr, valid_id, bubble_count); end
    step();
    vectors++; if (pc_id !== 32'h0C || imem_addr !== 32'h10) begin miscompares++; $display("FAIL pre_stall got id %h pc %h exp 0c 10", pc_id, imem_addr); end
    stalls = 5'b00011;
    for (int i = 1; i <= 2; i++) begin
      step();
      vectors++; if (imem_addr !== 32'h10 || pc_id !== 32'h0C || instr_id !== 32'h2400_000C || valid_id !== 1'b1) begin miscompares++; $display("FAIL stall_hold%0d got pc %h id %h i %h v%b exp 10 0c 2400000c v1", i, imem_addr, pc_id, instr_id, valid_id); end
      vectors++; if (stall_count !== i) begin miscompares++; $display("FAIL stall_cnt%0d got %0d exp %0d", i, stall_count, i); end
    end
    stalls = '0;
    step();
    vectors++; if (pc_id !== 32'h10 || instr_id !== 32'h2400_0010 || imem_addr !== 32'h14) begin miscompares++; $display("FAIL stall_resume got id %h i %h pc %h exp 10 24000010 14", pc_id, instr_id, imem_addr); end
    vectors++; if (fetch_count !== 32'd3 || stall_count !== 32'd2) begin miscompares++; $display("FAIL stall_counts got f%0d s%0d exp f3 s2", fetch_count, stall_count); end
  endtask

  task automatic test_redirect_priority();
    flushs = 5'b00010; stalls = 5'b00011;
    redirect_to(2'd1, 32'h40);
    flushs = '0; stalls = '0;
    vectors++; if (imem_addr !== 32'h40) begin miscompares++; $display("FAIL br_pc got %h exp 40", imem_addr); end
    vectors++; if (valid_id !== 1'b0 || instr_id !== 32'h0 || pc_id !== 32'h0) begin miscompares++; $display("FAIL br_bubble got v%b i %h id %h exp v0 0 0", valid_id, instr_id, pc_id); end
    vectors++; if (bubble_count !== 32'd2 || stall_count !== 32'd2) begin miscompares++; $display("FAIL br_cnt got b%0d s%0d exp b2 s2", bubble_count, stall_count); end
    step();
    vectors++; if (pc_id !== 32'h40 || instr_id !== 32'h2400_0040 || imem_addr !== 32'h44 || fetch_count !== 32'd4) begin miscompares++; $display("FAIL br_target got id %h i %h pc %h f%0d exp 40 24000040 44 4", pc_id, instr_id, imem_addr, fetch_count); end
  endtask

  task automatic test_syscall();
    redirect_to(2'd2, 32'h1C);
    step();
    vectors++; if (pc_id !== 32'h1C || imem_addr !== 32'h20 || halted !== 1'b0) begin miscompares++; $display("FAIL pre_sys got id %h pc %h h%b exp 1c 20 h0", pc_id, imem_addr, halted); end
    step();
    vectors++; if (halted !== 1'b1 || imem_addr !== 32'h20) begin miscompares++; $display("FAIL sys_halt got h%b pc %h exp h1 20", halted, imem_addr); end
    vectors++; if (instr_id !== 32'h0000_000C || pc_id !== 32'h20 || valid_id !== 1'b1 || fetch_count !== 32'd6) begin miscompares++; $display("FAIL sys_id got i %h id %h v%b f%0d exp c 20 v1 6", instr_id, pc_id, valid_id, fetch_count); end
    for (int i = 1; i <= 2; i++) begin
      step();
      vectors++; if (valid_id !== 1'b0 || imem_addr !== 32'h20 || halted !== 1'b1) begin miscompares++; $display("FAIL halt_bubble%0d got v%b pc %h h%b exp v0 20 h1", i, valid_id, imem_addr, halted); end
      vectors++; if (bubble_count !== 32'd3 + i || fetch_count !== 32'd6) begin miscompares++; $display("FAIL halt_cnt%0d got b%0d f%0d exp b%0d f6", i, bubble_count, fetch_count, 3 + i); end
    end
  endtask

  task automatic test_halt_exit();
    redirect_to(2'd2, 32'h80);
    vectors++; if (halted !== 1'b0 || imem_addr !== 32'h80 || valid_id !== 1'b0) begin miscompares++; $display("FAIL jexit got h%b pc %h v%b exp h0 80 v0", halted, imem_addr, valid_id); end
    step();
    vectors++; if (pc_id !== 32'h80 || valid_id !== 1'b1 || imem_addr !== 32'h84 || fetch_count !== 32'd7) begin miscompares++; $display("FAIL jexit_load got id %h v%b pc %h f%0d exp 80 v1 84 7", pc_id, valid_id, imem_addr, fetch_count); end
  endtask

  task automatic test_reset_in_halt();
    redirect_to(2'd1, 32'h20);
    step();
    step();
    vectors++; if (halted !== 1'b1 || bubble_count !== 32'd8 || fetch_count !== 32'd8) begin miscompares++; $display("FAIL rehalt got h%b b%0d f%0d exp h1 b8 f8", halted, bubble_count, fetch_count); end
    clr_n = 1'b0; stalls = 5'b00011;
    step();
    clr_n = 1'b1; stalls = '0;
    vectors++; if (halted !== 1'b0 || imem_addr !== 32'h100 || valid_id !== 1'b0) begin miscompares++; $display("FAIL hrst got h%b pc %h v%b exp h0 100 v0", halted, imem_addr, valid_id); end
    vectors++; if ({fetch_count, bubble_count, stall_count} !== 96'h0) begin miscompares++; $display("FAIL hrst_cnt got %h exp 0", {fetch_count, bubble_count, stall_count}); end
    step();
    vectors++; if (pc_id !== 32'h100 || instr_id !== 32'h2008_0001 || fetch_count !== 32'd1) begin miscompares++; $display("FAIL hrst_load got id %h i %h f%0d exp 100 20080001 1", pc_id, instr_id, fetch_count); end
  endtask

  task automatic test_wrap_and_if_stall();
    redirect_to(2'd2, 32'hFFFF_FFFC);
    step();
    vectors++; if (pc_id !== 32'hFFFF_FFFC || pc_plus4_id !== 32'h0 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap got id %h p4 %h pc %h exp fffffffc 0 0", pc_id, pc_plus4_id, imem_addr); end
    stalls = 5'b00001;
    step();
    stalls = '0;
    vectors++; if (imem_addr !== 32'h0 || valid_id !== 1'b0 || bubble_count !== 32'd2 || stall_count !== 32'd0) begin miscompares++; $display("FAIL if_stall got pc %h v%b b%0d s%0d exp 0 v0 b2 s0", imem_addr, valid_id, bubble_count, stall_count); end
    step();
    vectors++; if (pc_id !== 32'h0 || instr_id !== 32'h2400_0000 || valid_id !== 1'b1 || imem_addr !== 32'h4) begin miscompares++; $display("FAIL if_resume got id %h i %h v%b pc %h exp 0 24000000 v1 4", pc_id, instr_id, valid_id, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_priority();
    test_syscall();
    test_halt_exit();
    test_reset_in_halt();
    test_wrap_and_if_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
